// File: rtl/vga_pkg.sv
// Shared VGA constants and helpers: default 800x600@60 timing, coordinate
// width, colour constants used by the display blocks, and the layer
// priority composite function.
package vga_pkg;

    localparam int COORD_W    = 11;
    localparam int COLOUR_W   = 3;
    localparam int MAX_LAYERS = 16;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FRONT   = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BACK    = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FRONT   = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BACK    = 23;

    localparam logic [COLOUR_W-1:0] COLOUR_BG  = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_ON  = 3'b111;
    localparam logic [COLOUR_W-1:0] COLOUR_OFF = 3'b000;

    // Lowest-index layer with its display_on set wins; background otherwise.
    // Scans from the top down so the last assignment is the lowest index.
    function automatic logic [COLOUR_W-1:0] layer_select(
        input logic [COLOUR_W*MAX_LAYERS-1:0] pixels,
        input logic [MAX_LAYERS-1:0]          on,
        input logic [COLOUR_W-1:0]            bg
    );
        logic [COLOUR_W-1:0] sel;
        sel = bg;
        for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
            if (on[i]) begin
                sel = pixels[COLOUR_W*i +: COLOUR_W];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Coordinate / layer / video-out bundle between the timing generator
// (master) and the display blocks plus DAC side (slave).
// The test_pattern signal exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_generator_if #(
    parameter int NUM_LAYERS = 4
);
    logic [vga_pkg::COORD_W-1:0]             vga_h;
    logic [vga_pkg::COORD_W-1:0]             vga_v;
    logic                                    frame_start;
    logic [vga_pkg::COLOUR_W*NUM_LAYERS-1:0] layer_pixel;
    logic [NUM_LAYERS-1:0]                   layer_on;
`ifdef VGA_TEST_PATTERN_EN
    logic                                    test_pattern;
`endif
    logic [vga_pkg::COLOUR_W-1:0]            vga_rgb;
    logic                                    vga_hsync;
    logic                                    vga_vsync;

    modport master (
        output vga_h, output vga_v, output frame_start,
        output vga_rgb, output vga_hsync, output vga_vsync,
`ifdef VGA_TEST_PATTERN_EN
        input  test_pattern,
`endif
        input  layer_pixel, input layer_on
    );

    modport slave (
        input  vga_h, input vga_v, input frame_start,
        input  vga_rgb, input vga_hsync, input vga_vsync,
`ifdef VGA_TEST_PATTERN_EN
        output test_pattern,
`endif
        output layer_pixel, output layer_on
    );

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep sync/blank (and the bar
// coordinate) aligned with the display blocks' registered pixels.
// Synchronous reset clears every stage.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per clock; reset flushes the whole line to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: pixel/line counters, sync decode, sync/blank delay
// aligned with the display blocks' pixel pipeline, and layer compositing.
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars).
module vga_timing_generator #(
    parameter int              H_VISIBLE  = vga_pkg::DEF_H_VISIBLE,
    parameter int              H_FRONT    = vga_pkg::DEF_H_FRONT,
    parameter int              H_SYNC     = vga_pkg::DEF_H_SYNC,
    parameter int              H_BACK     = vga_pkg::DEF_H_BACK,
    parameter int              V_VISIBLE  = vga_pkg::DEF_V_VISIBLE,
    parameter int              V_FRONT    = vga_pkg::DEF_V_FRONT,
    parameter int              V_SYNC     = vga_pkg::DEF_V_SYNC,
    parameter int              V_BACK     = vga_pkg::DEF_V_BACK,
    parameter logic            SYNC_POL   = 1'b1,
    parameter int              NUM_LAYERS = 4,
    parameter int              PIPE_DELAY = 1,
    parameter logic [2:0]      COLOUR_BG  = vga_pkg::COLOUR_BG
) (
    input  logic                   clk,
    input  logic                   reset,
    vga_timing_generator_if.master bus
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int EXT_W   = COORD_W + 1;

    // One extra bit so a sync window ending exactly at 2048 still compares.
    localparam logic [EXT_W-1:0] HS_START = EXT_W'(H_VISIBLE + H_FRONT);
    localparam logic [EXT_W-1:0] HS_END   = EXT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [EXT_W-1:0] VS_START = EXT_W'(V_VISIBLE + V_FRONT);
    localparam logic [EXT_W-1:0] VS_END   = EXT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [EXT_W-1:0] H_VIS    = EXT_W'(H_VISIBLE);
    localparam logic [EXT_W-1:0] V_VIS    = EXT_W'(V_VISIBLE);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_too_big
        $error("vga_timing_generator: H_TOTAL/V_TOTAL must be <= 2048");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_bad_pipe_delay
        $error("vga_timing_generator: PIPE_DELAY must be 1..4");
    end
    if (NUM_LAYERS < 1 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_num_layers
        $error("vga_timing_generator: NUM_LAYERS out of range");
    end

    logic [COORD_W-1:0]             r_h;
    logic [COORD_W-1:0]             r_v;
    logic                           r_frame_start;
    logic [COORD_W-1:0]             w_h_next;
    logic [COORD_W-1:0]             w_v_next;
    logic                           w_hs_raw;
    logic                           w_vs_raw;
    logic                           w_vis_raw;
    logic [2:0]                     w_sync_d;
    logic [COLOUR_W*MAX_LAYERS-1:0] w_pix_ext;
    logic [MAX_LAYERS-1:0]          w_on_ext;
    logic [COLOUR_W-1:0]            w_composite;
    logic [COLOUR_W-1:0]            r_rgb;
    logic                           r_hsync;
    logic                           r_vsync;

    // Next counter values: h wraps at H_TOTAL-1, v advances only on that wrap.
    always_comb begin
        w_h_next = r_h + COORD_W'(1);
        w_v_next = r_v;
        if (r_h == COORD_W'(H_TOTAL - 1)) begin
            w_h_next = '0;
            if (r_v == COORD_W'(V_TOTAL - 1)) begin
                w_v_next = '0;
            end else begin
                w_v_next = r_v + COORD_W'(1);
            end
        end else begin
            w_v_next = r_v;
        end
    end

    // Counter registers; frame_start is registered from the next-state (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b1;
        end else begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
        end
    end

    // Compare-only decode of the sync windows and visible area.
    always_comb begin
        w_hs_raw  = ({1'b0, r_h} >= HS_START) && ({1'b0, r_h} < HS_END);
        w_vs_raw  = ({1'b0, r_v} >= VS_START) && ({1'b0, r_v} < VS_END);
        w_vis_raw = ({1'b0, r_h} < H_VIS) && ({1'b0, r_v} < V_VIS);
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk    (clk),
        .reset  (reset),
        .i_data ({w_hs_raw, w_vs_raw, w_vis_raw}),
        .o_data (w_sync_d)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_W-1:0] w_h_d;

    vga_delay_line #(
        .WIDTH (COORD_W),
        .DEPTH (PIPE_DELAY)
    ) u_h_delay (
        .clk    (clk),
        .reset  (reset),
        .i_data (r_h),
        .o_data (w_h_d)
    );
`endif

    // Priority composite of the layers (or colour bars when test_pattern is set).
    always_comb begin
        w_pix_ext = '0;
        w_on_ext  = '0;
        w_pix_ext[COLOUR_W*NUM_LAYERS-1:0] = bus.layer_pixel;
        w_on_ext[NUM_LAYERS-1:0]           = bus.layer_on;
`ifdef VGA_TEST_PATTERN_EN
        if (bus.test_pattern) begin
            w_composite = COLOUR_W'(w_h_d / COORD_W'(H_VISIBLE / 8));
        end else begin
            w_composite = layer_select(w_pix_ext, w_on_ext, COLOUR_BG);
        end
`else
        w_composite = layer_select(w_pix_ext, w_on_ext, COLOUR_BG);
`endif
    end

    // Output register: samples layers on the same edge; blanks outside visible area.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb   <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_rgb   <= w_sync_d[0] ? w_composite : 3'b000;
            r_hsync <= w_sync_d[2] ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_sync_d[1] ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.vga_h       = r_h;
    assign bus.vga_v       = r_v;
    assign bus.frame_start = r_frame_start;
    assign bus.vga_rgb     = r_rgb;
    assign bus.vga_hsync   = r_hsync;
    assign bus.vga_vsync   = r_vsync;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator. Horizontal timing is the
// real 800x600 line; the frame is shortened vertically to keep runs short.
`timescale 1ns/1ps
module tb_vga_timing_generator;

    localparam int HV = 800, HF = 40, HS = 128, HB = 88;
    localparam int VV = 8,   VF = 1,  VS = 4,   VB = 3;
    localparam int HT = HV + HF + HS + HB;   // 1056
    localparam int VT = VV + VF + VS + VB;   // 16
    localparam int FRAME = HT * VT;
    localparam int NL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    vga_timing_generator_if #(.NUM_LAYERS(NL)) bus();

    vga_timing_generator #(
        .V_VISIBLE  (VV),
        .V_FRONT    (VF),
        .V_SYNC     (VS),
        .V_BACK     (VB),
        .NUM_LAYERS (NL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [4:0]  sb_q[$];            // expected {rgb, hsync, vsync} per cycle
    int          exp_h    = 0;
    int          exp_v    = 0;
    logic        prev_rst = 1'b1;
    logic [2:0]  d_stage  = 3'b000;  // model of delayed {hs, vs, vis}
    int          d_h      = 0;
    logic        tp       = 1'b0;

    int hs_cnt, first_hs, line_len, vs_cnt, vs_rise, fs_cnt, fs_last, fs_int, n;
    logic prev_vs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] raw(input int h, input int v);
        raw = {(h >= HV + HF) && (h < HV + HF + HS),
               (v >= VV + VF) && (v < VV + VF + VS),
               (h < HV) && (v < VV)};
    endfunction

    function automatic logic [2:0] comp(input logic [3*NL-1:0] pix, input logic [NL-1:0] on);
        logic [2:0] c;
        bit found;
        c = 3'b000;
        found = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (!found && on[i]) begin
                c = pix[3*i +: 3];
                found = 1'b1;
            end
        end
        return c;
    endfunction

    // Drive one cycle of inputs, queue the output they produce next cycle,
    // advance to the following negedge and check counters and outputs.
    task automatic cycle(input logic rst, input logic [NL-1:0] on, input logic [3*NL-1:0] pix);
        logic [4:0] e;
        logic [2:0] colour;
        reset           = rst;
        bus.layer_on    = on;
        bus.layer_pixel = pix;
`ifdef VGA_TEST_PATTERN_EN
        bus.test_pattern = tp;
`endif
        colour = tp ? 3'((d_h / (HV / 8)) % 8) : comp(pix, on);
        if (rst) begin
            e = 5'b00000;
        end else begin
            e = {d_stage[0] ? colour : 3'b000, d_stage[2], d_stage[1]};
        end
        sb_q.push_back(e);
        d_stage  = rst ? 3'b000 : raw(exp_h, exp_v);
        d_h      = rst ? 0 : exp_h;
        prev_rst = rst;
        @(negedge clk);
        if (prev_rst) begin
            exp_h = 0;
            exp_v = 0;
        end else if (exp_h == HT - 1) begin
            exp_h = 0;
            exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
        end else begin
            exp_h = exp_h + 1;
        end
        check("vga_h", 32'(bus.vga_h), exp_h);
        check("vga_v", 32'(bus.vga_v), exp_v);
        check("frame_start", 32'(bus.frame_start), 32'(exp_h == 0 && exp_v == 0));
        check("rgb_hs_vs", 32'({bus.vga_rgb, bus.vga_hsync, bus.vga_vsync}), 32'(sb_q.pop_front()));
    endtask

    task automatic cycle_rand();
        logic [NL-1:0]   on;
        logic [3*NL-1:0] pix;
        on  = NL'($urandom);
        pix = (3*NL)'($urandom);
        cycle(1'b0, on, pix);
    endtask

    initial begin
        // Reset held for 5 cycles, then check the first cycle state.
        for (int i = 0; i < 5; i++) cycle(1'b1, '0, '0);
        check("rst_h", 32'(bus.vga_h), 0);
        check("rst_v", 32'(bus.vga_v), 0);
        check("rst_frame_start", 32'(bus.frame_start), 1);
        check("rst_rgb", 32'(bus.vga_rgb), 0);
        check("rst_hsync", 32'(bus.vga_hsync), 0);
        check("rst_vsync", 32'(bus.vga_vsync), 0);

        // One full line: hsync width, position and line length.
        hs_cnt = 0; first_hs = -1; line_len = -1;
        for (int i = 1; i <= HT; i++) begin
            cycle_rand();
            if (bus.vga_hsync === 1'b1) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = int'(bus.vga_h);
            end
            if (bus.vga_h == 0 && line_len < 0) line_len = i;
        end
        check("hsync_width", hs_cnt, HS);
        check("hsync_start_h", first_hs, HV + HF + 2);
        check("line_length", line_len, HT);

        // Layer priority at visible (10,6): layers present in the following cycle.
        n = 0;
        while (n < FRAME && !(bus.vga_h == 11 && bus.vga_v == 6)) begin
            cycle_rand();
            n++;
        end
        check("wait_vis_point", 32'(n < FRAME), 1);
        cycle(1'b0, 4'b0110, {3'b111, 3'b010, 3'b100, 3'b011});
        check("layer_rgb_visible", 32'(bus.vga_rgb), 32'(3'b100));

        // Same stimulus outside the visible area blanks.
        n = 0;
        while (n < HT && !(bus.vga_h == 901)) begin
            cycle_rand();
            n++;
        end
        check("wait_blank_point", 32'(n < HT), 1);
        cycle(1'b0, 4'b0110, {3'b111, 3'b010, 3'b100, 3'b011});
        check("layer_rgb_blank", 32'(bus.vga_rgb), 0);

        // Two frames: vsync placement/width and frame_start period.
        vs_cnt = 0; vs_rise = 0; fs_cnt = 0; fs_last = -1; fs_int = -1;
        prev_vs = bus.vga_vsync;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cycle_rand();
            if (bus.vga_vsync === 1'b1) vs_cnt++;
            if (bus.vga_vsync === 1'b1 && prev_vs === 1'b0) begin
                vs_rise++;
                check("vsync_start_v", 32'(bus.vga_v), VV + VF);
                check("vsync_start_h", 32'(bus.vga_h), 2);
            end
            prev_vs = bus.vga_vsync;
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_last >= 0) fs_int = i - fs_last;
                fs_last = i;
            end
        end
        check("vsync_rises", vs_rise, 2);
        check("vsync_cycles", vs_cnt, 2 * VS * HT);
        check("frame_start_count", fs_cnt, 2);
        check("frame_start_period", fs_int, FRAME);

        // Mid-line reset at (500,7).
        n = 0;
        while (n < FRAME && !(bus.vga_h == 500 && bus.vga_v == 7)) begin
            cycle_rand();
            n++;
        end
        check("wait_reset_point", 32'(n < FRAME), 1);
        cycle(1'b1, 4'b0001, {9'b0, 3'b101});
        check("mid_rst_h", 32'(bus.vga_h), 0);
        check("mid_rst_v", 32'(bus.vga_v), 0);
        check("mid_rst_rgb0", 32'(bus.vga_rgb), 0);
        check("mid_rst_sync0", 32'({bus.vga_hsync, bus.vga_vsync}), 0);
        cycle(1'b0, 4'b0001, {9'b0, 3'b101});
        check("mid_rst_rgb1", 32'(bus.vga_rgb), 0);
        check("mid_rst_sync1", 32'({bus.vga_hsync, bus.vga_vsync}), 0);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars across one visible line.
        tp = 1'b1;
        n = 0;
        while (n < FRAME && !(bus.vga_h == 0 && bus.vga_v == 1)) begin
            cycle_rand();
            n++;
        end
        check("wait_bar_line", 32'(n < FRAME), 1);
        for (int i = 0; i < HT; i++) begin
            cycle_rand();
            if (bus.vga_h >= 2 && bus.vga_h < HV + 2)
                check("bar_colour", 32'(bus.vga_rgb), (int'(bus.vga_h) - 2) / (HV / 8));
        end
        tp = 1'b0;
`endif

        for (int i = 0; i < 4; i++) cycle_rand();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
